// File: rtl/tpu_pkg.sv
// Shared constants and FSM state encoding for the TPU tile scheduler.
// Optional perf counters in the scheduler are enabled by TPU_TILE_SCHED_PERF_EN.
package tpu_pkg;

  localparam int TILE          = 4;
  localparam int TILE_SHIFT    = $clog2(TILE);
  localparam int DIM_BITS_DEF  = 8;
  localparam int ADDR_BITS_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_FINISH
  } sched_state_t;

endpackage

// File: rtl/tpu_tile_addr_gen.sv
// Output-tile walker: m/n tile indices (n inner), last-tile flag and the
// registered A/B/C base addresses for the current tile.
module tpu_tile_addr_gen
  import tpu_pkg::*;
#(
  parameter int DIM_BITS  = DIM_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [DIM_BITS-1:0]  k,
  input  logic [DIM_BITS-1:0]  m,
  input  logic [DIM_BITS-1:0]  n,
  output logic [ADDR_BITS-1:0] a_base,
  output logic [ADDR_BITS-1:0] b_base,
  output logic [ADDR_BITS-1:0] c_base,
  output logic                 last
);

  localparam int CW = DIM_BITS + 1;

  logic [CW-1:0]        mt;
  logic [CW-1:0]        nt;
  logic [CW-1:0]        m_idx_reg;
  logic [CW-1:0]        n_idx_reg;
  logic [CW-1:0]        m_idx_next;
  logic [CW-1:0]        n_idx_next;
  logic                 n_wrap;
  logic [ADDR_BITS-1:0] a_next;
  logic [ADDR_BITS-1:0] b_next;
  logic [ADDR_BITS-1:0] c_next;

  // One extra bit keeps the ceil() from overflowing at the top of the range.
  assign mt = ({1'b0, m} + CW'(TILE - 1)) >> TILE_SHIFT;
  assign nt = ({1'b0, n} + CW'(TILE - 1)) >> TILE_SHIFT;

  assign n_wrap = (n_idx_reg == nt - CW'(1));
  assign last   = n_wrap && (m_idx_reg == mt - CW'(1));

  always_comb begin
    m_idx_next = m_idx_reg;
    n_idx_next = n_idx_reg + CW'(1);
    if (n_wrap) begin
      n_idx_next = '0;
      m_idx_next = m_idx_reg + CW'(1);
    end
  end

  // Bases are computed from the next indices so they land together with them.
  assign a_next = ADDR_BITS'(m_idx_next) * ADDR_BITS'(k);
  assign b_next = ADDR_BITS'(n_idx_next) * ADDR_BITS'(k);
  assign c_next = (ADDR_BITS'(m_idx_next) * ADDR_BITS'(nt) + ADDR_BITS'(n_idx_next)) << TILE_SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx_reg <= '0;
      n_idx_reg <= '0;
      a_base    <= '0;
      b_base    <= '0;
      c_base    <= '0;
    end else if (clear) begin
      m_idx_reg <= '0;
      n_idx_reg <= '0;
      a_base    <= '0;
      b_base    <= '0;
      c_base    <= '0;
    end else if (advance) begin
      m_idx_reg <= m_idx_next;
      n_idx_reg <= n_idx_next;
      a_base    <= a_next;
      b_base    <= b_next;
      c_base    <= c_next;
    end
  end

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Splits an M x K x N matmul into 4x4 output tiles and issues one core job per tile.
// Define TPU_TILE_SCHED_PERF_EN to add the perf_cycles/perf_jobs counters.
module tpu_tile_scheduler
  import tpu_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DIM_BITS  = DIM_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIM_BITS-1:0]  K,
  input  logic [DIM_BITS-1:0]  M,
  input  logic [DIM_BITS-1:0]  N,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 job_valid,
  input  logic                 job_ready,
  input  logic                 job_done,
  output logic [ADDR_BITS-1:0] job_a_base,
  output logic [ADDR_BITS-1:0] job_b_base,
  output logic [ADDR_BITS-1:0] job_c_base,
  output logic [DIM_BITS-1:0]  job_k
`ifdef TPU_TILE_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [15:0]          perf_jobs
`endif
);

  sched_state_t        state_reg;
  logic [DIM_BITS-1:0] k_reg;
  logic [DIM_BITS-1:0] m_reg;
  logic [DIM_BITS-1:0] n_reg;
  logic                zero_dims;
  logic                last_tile;
  logic                addr_clear;
  logic                addr_advance;

  assign zero_dims    = (k_reg == '0) || (m_reg == '0) || (n_reg == '0);
  assign addr_clear   = (state_reg == ST_CHECK);
  assign addr_advance = (state_reg == ST_NEXT) && !abort && !last_tile;
  assign job_k        = k_reg;

  tpu_tile_addr_gen #(
    .DIM_BITS  (DIM_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (addr_clear),
    .advance (addr_advance),
    .k       (k_reg),
    .m       (m_reg),
    .n       (n_reg),
    .a_base  (job_a_base),
    .b_base  (job_b_base),
    .c_base  (job_c_base),
    .last    (last_tile)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      job_valid <= 1'b0;
      k_reg     <= '0;
      m_reg     <= '0;
      n_reg     <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            k_reg     <= K;
            m_reg     <= M;
            n_reg     <= N;
            busy      <= 1'b1;
            aborted   <= 1'b0;
            state_reg <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (zero_dims) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= ST_FINISH;
          end else begin
            job_valid <= 1'b1;
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Abort wins over a same-cycle handshake: the job is withdrawn.
          if (abort) begin
            job_valid <= 1'b0;
            aborted   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= ST_FINISH;
          end else if (job_ready) begin
            job_valid <= 1'b0;
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (job_done) begin
            state_reg <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (abort || last_tile) begin
            aborted   <= abort && !last_tile;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= ST_FINISH;
          end else begin
            job_valid <= 1'b1;
            state_reg <= ST_ISSUE;
          end
        end
        ST_FINISH: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef TPU_TILE_SCHED_PERF_EN
  logic start_accept;
  logic hs_accept;

  assign start_accept = (state_reg == ST_IDLE) && start;
  assign hs_accept    = (state_reg == ST_ISSUE) && !abort && job_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_jobs   <= '0;
    end else if (start_accept) begin
      perf_cycles <= '0;
      perf_jobs   <= '0;
    end else begin
      if (busy && (perf_cycles != '1)) begin
        perf_cycles <= perf_cycles + 32'd1;
      end
      if (hs_accept) begin
        perf_jobs <= perf_jobs + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Directed self-checking bench for tpu_tile_scheduler with an inline core model
// that answers each handshake with job_done three cycles later.
module tb_tpu_tile_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  k_in;
  logic [7:0]  m_in;
  logic [7:0]  n_in;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        job_valid;
  logic        job_ready;
  logic        job_done;
  logic [15:0] job_a_base;
  logic [15:0] job_b_base;
  logic [15:0] job_c_base;
  logic [7:0]  job_k;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_a[8];
  int exp_b[8];
  int exp_c[8];
  int hs[8];

  tpu_tile_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .K          (k_in),
    .M          (m_in),
    .N          (n_in),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_done   (job_done),
    .job_a_base (job_a_base),
    .job_b_base (job_b_base),
    .job_c_base (job_c_base),
    .job_k      (job_k)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int i, input int a, input int b, input int c);
    exp_a[i] = a;
    exp_b[i] = b;
    exp_c[i] = c;
  endtask

  // Runs one command; abort_job/stall_job/rst_job select optional disturbances (-1 = none).
  task automatic run_cmd(input string tag, input int m, input int k, input int n,
                         input int abort_job, input int stall_job, input int rst_job,
                         input int exp_jobs, input logic exp_aborted);
    int cyc, pend, njobs, first_v, done_cyc, stall;
    bit stable_ok, rst_hit;
    int got_a[8], got_b[8], got_c[8], got_k[8];
    cyc = 0; pend = -1; njobs = 0; first_v = -1; done_cyc = -1; stall = 0;
    stable_ok = 1'b1; rst_hit = 1'b0;
    m_in = 8'(m); k_in = 8'(k); n_in = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check_val({tag, "_busy_t1"}, 32'(busy), 1);
    check_val({tag, "_valid_t1"}, 32'(job_valid), 0);
    check_val({tag, "_aborted_clr"}, 32'(aborted), 0);
    while (cyc < 400) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (rst_job > 0 && njobs == rst_job && cyc == hs[rst_job-1] + 1) begin
        rst_n = 1'b0;
        #1;
        check_val({tag, "_rst_busy"}, 32'(busy), 0);
        check_val({tag, "_rst_valid"}, 32'(job_valid), 0);
        check_val({tag, "_rst_a"}, 32'(job_a_base), 0);
        check_val({tag, "_rst_b"}, 32'(job_b_base), 0);
        check_val({tag, "_rst_c"}, 32'(job_c_base), 0);
        check_val({tag, "_rst_k"}, 32'(job_k), 0);
        rst_n = 1'b1;
        rst_hit = 1'b1;
        break;
      end
      job_done = (cyc == pend);
      abort = (abort_job > 0 && njobs >= abort_job);
      if (njobs == stall_job && stall < 10 && (stall > 0 || job_valid)) begin
        job_ready = 1'b0;
        if (!job_valid || job_a_base != 16'(exp_a[njobs]) || job_b_base != 16'(exp_b[njobs]) ||
            job_c_base != 16'(exp_c[njobs]))
          stable_ok = 1'b0;
        start = (stall == 3);
        if (stall == 3) begin
          m_in = 8'd0; k_in = 8'd0; n_in = 8'd0;
        end
        if (stall == 5) job_done = 1'b1;
        stall++;
      end else begin
        job_ready = 1'b1;
        start = 1'b0;
      end
      if (job_valid && first_v < 0) first_v = cyc;
      if (job_valid && job_ready && !abort) begin
        if (njobs < 8) begin
          got_a[njobs] = int'(job_a_base);
          got_b[njobs] = int'(job_b_base);
          got_c[njobs] = int'(job_c_base);
          got_k[njobs] = int'(job_k);
          hs[njobs] = cyc;
        end
        $display("%s job %0d: a=%0d b=%0d c=%0d k=%0d cycle %0d", tag, njobs,
                 job_a_base, job_b_base, job_c_base, job_k, cyc);
        pend = cyc + 3;
        njobs++;
      end
      tick();
      cyc++;
    end
    job_done = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    job_ready = 1'b1;
    if (rst_hit) return;
    check_val({tag, "_done_seen"}, 32'(done_cyc > 0), 1);
    check_val({tag, "_jobs"}, 32'(njobs), 32'(exp_jobs));
    for (int i = 0; i < exp_jobs && i < njobs && i < 8; i++) begin
      check_val($sformatf("%s_a%0d", tag, i), 32'(got_a[i]), 32'(exp_a[i]));
      check_val($sformatf("%s_b%0d", tag, i), 32'(got_b[i]), 32'(exp_b[i]));
      check_val($sformatf("%s_c%0d", tag, i), 32'(got_c[i]), 32'(exp_c[i]));
      check_val($sformatf("%s_k%0d", tag, i), 32'(got_k[i]), 32'(k));
    end
    check_val({tag, "_aborted"}, 32'(aborted), 32'(exp_aborted));
    check_val({tag, "_busy_at_done"}, 32'(busy), 0);
    if (exp_jobs == 0) begin
      check_val({tag, "_done_lat"}, 32'(done_cyc), 2);
      check_val({tag, "_no_valid"}, 32'(first_v < 0), 1);
    end else if (stall_job < 0 && njobs == exp_jobs) begin
      check_val({tag, "_first_valid"}, 32'(first_v), 2);
      check_val({tag, "_done_lat"}, 32'(done_cyc - hs[njobs-1]), 5);
      if (njobs >= 2) check_val({tag, "_job_gap"}, 32'(hs[1] - hs[0]), 5);
    end
    if (stall_job >= 0) begin
      check_val({tag, "_stall_stable"}, 32'(stable_ok), 1);
      check_val({tag, "_stall_len"}, 32'(stall), 10);
    end
    $display("%s command end: jobs=%0d aborted=%0d done cycle %0d", tag, njobs, aborted, done_cyc);
    tick();
    check_val({tag, "_done_pulse"}, 32'(done), 0);
    check_val({tag, "_aborted_hold"}, 32'(aborted), 32'(exp_aborted));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    job_ready = 1'b1; job_done = 1'b0;
    k_in = 8'd0; m_in = 8'd0; n_in = 8'd0;
    tick();
    tick();
    check_val("reset_busy", 32'(busy), 0);
    check_val("reset_done", 32'(done), 0);
    check_val("reset_aborted", 32'(aborted), 0);
    check_val("reset_valid", 32'(job_valid), 0);
    check_val("reset_bases", 32'(job_a_base | job_b_base | job_c_base), 0);
    check_val("reset_k", 32'(job_k), 0);
    rst_n = 1'b1;
    tick();

    set_job(0, 0, 0, 0); set_job(1, 0, 4, 4); set_job(2, 4, 0, 8); set_job(3, 4, 4, 12);
    run_cmd("m8k4n8", 8, 4, 8, -1, -1, -1, 4, 1'b0);
    tick();

    set_job(0, 0, 0, 0); set_job(1, 6, 0, 4);
    run_cmd("m5k6n3", 5, 6, 3, -1, -1, -1, 2, 1'b0);
    tick();

    run_cmd("k0", 4, 0, 4, -1, -1, -1, 0, 1'b0);
    tick();

    set_job(0, 0, 0, 0); set_job(1, 0, 4, 4);
    run_cmd("abort", 8, 4, 8, 2, -1, -1, 2, 1'b1);
    tick();

    set_job(0, 0, 0, 0); set_job(1, 0, 2, 4);
    run_cmd("stall", 4, 2, 8, -1, 1, -1, 2, 1'b0);
    tick();

    set_job(0, 0, 0, 0); set_job(1, 0, 4, 4);
    run_cmd("rst_wait", 8, 4, 8, -1, -1, 2, 0, 1'b0);
    tick();
    tick();

    set_job(0, 0, 0, 0); set_job(1, 0, 4, 4); set_job(2, 4, 0, 8); set_job(3, 4, 4, 12);
    run_cmd("after_rst", 8, 4, 8, -1, -1, -1, 4, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
